// File: rtl/cmem_port_arbiter.sv
// cmem_port_arbiter
// Three requesters share one layer-memory port. Round-robin picks one transaction
// per cycle, and the requester granted last cycle is skipped this cycle. Read data
// comes back to its owner two edges after the grant edge.
//
// Handshake: a requester holds req (and its we/sel/addr/wdata) stable until it sees
// its gnt bit high. At that edge it may present a new transaction or drop req. gnt
// and rvalid are single-cycle one-hot pulses. rdata is meaningful only while rvalid
// is nonzero. A requester may drop req before it is granted, with no side effect.
module cmem_port_arbiter #(
    parameter int AW   = 12,
    parameter int DW   = 13,
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ-1:0]    req_sel,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               cwr,
    output logic               crd,
    output logic               csel,
    output logic [AW-1:0]      caddr_wr,
    output logic [DW-1:0]      cdata_wr,
    output logic [AW-1:0]      caddr_rd,
    input  logic [DW-1:0]      cdata_rd
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [1:0]      rr_ptr;
    logic [1:0]      start;
    logic [NREQ-1:0] elig;
    logic [2:0]      cand;
    logic            win_valid;
    logic [1:0]      win_idx;
    logic [NREQ-1:0] win_oh;
    logic [1:0]      rr_next;
    logic [NREQ-1:0] rd_own1;
    logic [NREQ-1:0] rd_own2;

    // Winner selection: scan from rr_ptr and wrap at 3. The requester granted last
    // cycle is masked. A pointer corrupted to 3 is treated as 0.
    always_comb begin
        start     = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
        elig      = req & ~gnt;
        cand      = '0;
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, start} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!win_valid && elig[cand[1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[1:0];
            end
        end
        win_oh  = ONE << win_idx;
        rr_next = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end

    // Issue stage: register the grant and drive the memory command for one cycle.
    // Address, data and csel keep their last values while the port is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            rr_ptr   <= 2'd0;
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= 1'b0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            caddr_rd <= '0;
        end else begin
            if (win_valid) begin
                gnt    <= win_oh;
                rr_ptr <= rr_next;
                csel   <= req_sel[win_idx];
                if (req_we[win_idx]) begin
                    cwr      <= 1'b1;
                    crd      <= 1'b0;
                    caddr_wr <= req_addr[win_idx*AW +: AW];
                    cdata_wr <= req_wdata[win_idx*DW +: DW];
                end else begin
                    cwr      <= 1'b0;
                    crd      <= 1'b1;
                    caddr_rd <= req_addr[win_idx*AW +: AW];
                end
            end else begin
                gnt <= '0;
                cwr <= 1'b0;
                crd <= 1'b0;
            end
        end
    end

    // Read return: track the owner of each issued read through two stages. When the
    // owner leaves the second stage, memory data is present, so capture it then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_own1 <= '0;
            rd_own2 <= '0;
            rvalid  <= '0;
            rdata   <= '0;
        end else begin
            rd_own1 <= (win_valid && !req_we[win_idx]) ? win_oh : '0;
            rd_own2 <= rd_own1;
            rvalid  <= rd_own2;
            if (|rd_own2) begin
                rdata <= cdata_rd;
            end
        end
    end

endmodule

// File: tb/tb_cmem_port_arbiter.sv
// tb_cmem_port_arbiter
// Directed scenarios followed by a random traffic phase. A behavioural model
// predicts every output of the arbiter. The model holds a round-robin pointer and
// the last winner as integers, a shadow memory, and a queue of expected read
// returns with due cycles.
module tb_cmem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 13;
    localparam int NR = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]    req, req_we, req_sel;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata;
    logic             cwr, crd, csel;
    logic [AW-1:0]    caddr_wr, caddr_rd;
    logic [DW-1:0]    cdata_wr, cdata_rd;

    cmem_port_arbiter #(.AW(AW), .DW(DW), .NREQ(NR)) dut (
        .clk(clk), .reset(reset),
        .req(req), .req_we(req_we), .req_sel(req_sel),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .cwr(cwr), .crd(crd), .csel(csel),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd)
    );

    // ---------------- memory device (L0 at 0..4095, L1 at 4096..8191) ----------------
    logic [DW-1:0] mem [0:8191];
    logic [DW-1:0] exp_mem [0:8191];

    function automatic logic [DW-1:0] init_word(input int idx);
        return DW'(idx * 37 + 11);
    endfunction

    // Synchronous memory: a read sampled at an edge returns data that edge, and a
    // write commits at the edge where cwr is seen.
    always @(posedge clk) begin
        if (crd) cdata_rd <= mem[{csel, caddr_rd}];
        if (cwr) mem[{csel, caddr_wr}] = cdata_wr;
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q [$];
    int            own_q [$];
    int            due_q [$];

    int            t;
    int            ptr;
    int            last_w;
    logic [NR-1:0] e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata, e_cdata_wr;
    logic          e_cwr, e_crd, e_csel;
    logic [AW-1:0] e_caddr_wr, e_caddr_rd;
    logic          e_in_reset;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr = 0; last_w = -1;
        e_gnt = '0; e_rvalid = '0; e_rdata = '0;
        e_cwr = 1'b0; e_crd = 1'b0; e_csel = 1'b0;
        e_caddr_wr = '0; e_cdata_wr = '0; e_caddr_rd = '0;
        e_in_reset = 1'b1;
        exp_q.delete(); own_q.delete(); due_q.delete();
    endtask

    // One rising edge of the model, evaluated on the inputs presented before it.
    task automatic model_edge();
        int w;
        if (reset) begin
            model_reset();
            return;
        end
        e_in_reset = 1'b0;
        t++;
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (ptr + k) % 3;
            if (w < 0 && req[i] && i != last_w) w = i;
        end
        if (w >= 0) begin
            ptr   = (w + 1) % 3;
            e_gnt = NR'(1 << w);
            e_csel = req_sel[w];
            if (req_we[w]) begin
                e_cwr = 1'b1; e_crd = 1'b0;
                e_caddr_wr = req_addr[w*AW +: AW];
                e_cdata_wr = req_wdata[w*DW +: DW];
                exp_mem[{req_sel[w], e_caddr_wr}] = e_cdata_wr;
            end else begin
                e_cwr = 1'b0; e_crd = 1'b1;
                e_caddr_rd = req_addr[w*AW +: AW];
                exp_q.push_back(exp_mem[{req_sel[w], e_caddr_rd}]);
                own_q.push_back(w);
                due_q.push_back(t + 2);
            end
            last_w = w;
        end else begin
            e_gnt = '0; e_cwr = 1'b0; e_crd = 1'b0;
            last_w = -1;
        end
        e_rvalid = '0;
        if (due_q.size() > 0 && due_q[0] == t) begin
            e_rvalid = NR'(1 << own_q[0]);
            e_rdata  = exp_q.pop_front();
            void'(own_q.pop_front());
            void'(due_q.pop_front());
        end
    endtask

    task automatic check_outputs();
        check("gnt",      32'(gnt),      32'(e_gnt));
        check("rvalid",   32'(rvalid),   32'(e_rvalid));
        check("cwr",      32'(cwr),      32'(e_cwr));
        check("crd",      32'(crd),      32'(e_crd));
        check("csel",     32'(csel),     32'(e_csel));
        check("caddr_wr", 32'(caddr_wr), 32'(e_caddr_wr));
        check("cdata_wr", 32'(cdata_wr), 32'(e_cdata_wr));
        check("caddr_rd", 32'(caddr_rd), 32'(e_caddr_rd));
        if (e_rvalid != '0 || e_in_reset) check("rdata", 32'(rdata), 32'(e_rdata));
    endtask

    // One clock: model at the rising edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic we, input logic sel,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req[i] = 1'b1; req_we[i] = we; req_sel[i] = sel;
        req_addr[i*AW +: AW] = addr;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic drive_random();
        for (int i = 0; i < NR; i++) begin
            if (gnt[i] || !req[i]) begin
                if ($urandom_range(0, 9) < 6)
                    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            AW'($urandom_range(0, 15)), DW'($urandom));
                else
                    req[i] = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NR-1:0] prev_gnt;
        for (int i = 0; i < 8192; i++) begin
            mem[i] = init_word(i);
            exp_mem[i] = init_word(i);
        end
        mem[12'h0C2] = 13'h0055;
        exp_mem[12'h0C2] = 13'h0055;
        t = 0;
        reset = 1'b1;
        req = '0; req_we = '0; req_sel = '0; req_addr = '0; req_wdata = '0;
        model_reset();
        step();
        step();
        @(negedge clk);
        reset = 1'b0;

        // 1: R0 write
        set_req(0, 1'b1, 1'b0, 12'h041, 13'h0123);
        step();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_cwr", 32'(cwr), 32'h1);
        check("t1_addr", 32'(caddr_wr), 32'h041);
        check("t1_data", 32'(cdata_wr), 32'h0123);
        check("t1_csel", 32'(csel), 32'h0);
        req[0] = 1'b0;
        step();
        check("t1_cwr_off", 32'(cwr), 32'h0);

        // 2: R1 read L0 0x0C2
        set_req(1, 1'b0, 1'b0, 12'h0C2, 13'h0);
        step();
        check("t2_gnt", 32'(gnt), 32'h2);
        check("t2_crd", 32'(crd), 32'h1);
        req[1] = 1'b0;
        step();
        check("t2_crd_off", 32'(crd), 32'h0);
        check("t2_early", 32'(rvalid), 32'h0);
        step();
        check("t2_rvalid", 32'(rvalid), 32'h2);
        check("t2_rdata", 32'(rdata), 32'h0055);
        step();

        // 3: all three requesting continuously
        set_req(0, 1'b1, 1'b0, 12'h009, 13'h0777);
        set_req(1, 1'b0, 1'b0, 12'h009, 13'h0);
        set_req(2, 1'b0, 1'b1, 12'h003, 13'h0);
        step();
        prev_gnt = gnt;
        for (int c = 0; c < 9; c++) begin
            step();
            check("t3_nogap", 32'(gnt != '0), 32'h1);
            check("t3_norepeat", 32'(gnt == prev_gnt), 32'h0);
            prev_gnt = gnt;
        end

        // 4: only R2 requesting
        req[0] = 1'b0; req[1] = 1'b0;
        step();
        step();
        prev_gnt = gnt;
        for (int c = 0; c < 8; c++) begin
            step();
            check("t4_alt", 32'(gnt[2] != prev_gnt[2]), 32'h1);
            if (e_gnt == '0) check("t4_idle", 32'({cwr, crd}), 32'h0);
            prev_gnt = gnt;
        end
        req = '0;
        for (int c = 0; c < 3; c++) step();

        // 5: write then read same address, then R1/R2 back-to-back reads
        set_req(0, 1'b1, 1'b0, 12'h005, 13'h0AAA);
        step();
        req[0] = 1'b0;
        set_req(1, 1'b0, 1'b0, 12'h005, 13'h0);
        set_req(2, 1'b0, 1'b1, 12'h005, 13'h0);
        step();
        check("t5_gnt_r1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        step();
        check("t5_gnt_r2", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        step();
        check("t5_rvalid_r1", 32'(rvalid), 32'h2);
        check("t5_rdata_r1", 32'(rdata), 32'h0AAA);
        step();
        check("t5_rvalid_r2", 32'(rvalid), 32'h4);
        step();

        // 6: reset while an R2 read is in flight
        set_req(2, 1'b0, 1'b1, 12'h007, 13'h0);
        step();
        check("t6_gnt", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        step();
        reset = 1'b1;
        set_req(1, 1'b0, 1'b0, 12'h00A, 13'h0);
        set_req(2, 1'b0, 1'b0, 12'h00B, 13'h0);
        step();
        check("t6_rvalid_rst", 32'(rvalid), 32'h0);
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("t6_first_r1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (gnt[2]) req[2] = 1'b0;
        end

        // random traffic
        for (int c = 0; c < 400; c++) begin
            drive_random();
            step();
        end
        req = '0;
        for (int c = 0; c < 5; c++) step();
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
